onehot_encoder_pipe: RTL and testbench
======================================

// Module: onehot_encoder_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 5-to-3 one-hot encoder. Converts an
//  N-bit request vector to a binary index. It has a selectable strict-one-hot or
//  lowest-first priority mode, invalid-vector detection and a saturating error
//  counter. A valid/ready stream stage with a skid register lets it sit between
//  arbiters and mux-select logic without breaking timing.
// PARAMETERS
//  N        5   input vector width, 2..64
//  IDX_W    $clog2(N)  output index width (derived, not overridden)
//  MODE     0   0 = strict one-hot; 1 = priority, lowest set bit wins
//  CNT_W    16  width of the saturating error counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      in_vec valid
//  in_ready   out  1      block can accept in_vec
//  in_vec     in   N      request vector
//  out_valid  out  1      out_* valid
//  out_ready  in   1      downstream accepts out_*
//  out_idx    out  IDX_W  encoded index
//  out_hit    out  1      in_vec had at least one bit set
//  out_err    out  1      vector invalid for MODE
//  err_cnt    out  CNT_W  count of accepted vectors with out_err=1, saturating
//  err_clr    in   1      synchronous clear of err_cnt
// BEHAVIOUR
//  Reset: out_valid=0, out_idx=0, out_hit=0, out_err=0, err_cnt=0, skid empty,
//   in_ready=1 from the first cycle after reset release.
//  Accept: in_valid&in_ready on an edge. Transfer: out_valid&out_ready on an edge.
//  Encode, combinational ahead of the output register:
//   MODE0: exactly one bit k set -> idx=k, err=0. Zero or multi-hot -> idx=0, err=1.
//   MODE1: lowest set bit k -> idx=k, err=0. Zero -> idx=0, err=1.
//   hit = |in_vec in both modes.
//  Latency: 1 cycle. A vector accepted on edge t is on out_* after edge t.
//  Throughput: 1 vector/cycle while out_ready=1.
//  Storage: output register plus one skid register.
//   in_ready = !skid_full. This is a registered signal, with no combinational path
//   from out_ready.
//   If an accept occurs while out is valid and not transferred, the vector goes to
//    the skid register and skid_full is set.
//   On transfer with skid_full, skid moves to out and skid_full clears.
//   Simultaneous accept and transfer with skid empty: the new vector goes straight
//    to out.
//   Stream order is always preserved, with no drops or duplicates.
//   out_* hold stable while out_valid=1 and out_ready=0.
//  err_cnt increments on accept of a vector with err=1. It saturates at 2^CNT_W-1.
//   err_clr has priority over a same-cycle increment: the result is 0.
//  Async reset mid-stream discards the out and skid contents. There is no partial
//   output.
//  in_vec bits at or above N do not exist. idx is always < N.
// STRUCTURE
//  encoder_pkg holds the mode constants ENC_MODE_STRICT=0 and ENC_MODE_PRIO=1, and
//   the function clog2_f. MODE is compared against these constants only.
//  Encode logic is one function: a loop from bit N-1 down to 0, plus a popcount>1
//   check for MODE0.
//  One sub-module, stream_skid_reg, carries the valid/ready output register and skid
//   register. It is parametrised by payload width, which is IDX_W+2.
// TESTING
//  1. N=5, MODE0, out_ready=1. Input 00001,00010,00100,01000,10000 back to back ->
//     idx 0,1,2,3,4, err=0, one per cycle, latency 1, err_cnt=0.
//  2. N=5, MODE0. Input 00000 -> idx=0 hit=0 err=1. Input 00110 -> idx=0 hit=1
//     err=1. Then err_cnt=2.
//  3. N=8, MODE1. Input 10110100 -> idx=2 err=0. Input 10000000 -> idx=7.
//     Input 00000000 -> err=1.
//  4. Backpressure. Hold out_ready=0 and send A,B -> in_ready=0 after B, out holds A.
//     Raise out_ready -> A then B delivered in order, and in_ready returns to 1.
//  5. CNT_W=2. Send 5 invalid vectors -> err_cnt stops at 3. Assert err_clr with an
//     invalid accept in the same cycle -> err_cnt=0.
//  6. Assert rst_n low with both registers full -> out_valid=0 and in_ready=1 after
//     release, and no stale vector is emitted.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the pipelined one-hot encoder.
// Mode selectors and a constant-evaluable ceil(log2) for width derivation.
package encoder_pkg;

  localparam int ENC_MODE_STRICT = 0;
  localparam int ENC_MODE_PRIO   = 1;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_skid_reg.sv
// Valid/ready stage: output register plus one skid register.
// Ports: in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data down.
module stream_skid_reg
  import encoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic         skid_full_q, skid_full_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         acc, xfer;

  // in_ready comes straight from a flop, so out_ready
  // never reaches it combinationally.
  assign in_ready  = !skid_full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    acc  = in_valid && !skid_full_q;
    xfer = out_valid_q && out_ready;
    if (skid_full_q) begin
      // No accept possible here: in_ready is low.
      if (xfer) begin
        out_data_d  = skid_data_q;
        skid_full_d = 1'b0;
      end
    end else if (acc) begin
      if (!out_valid_q || xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        skid_full_d = 1'b1;
        skid_data_d = in_data;
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Pipelined N-bit one-hot/priority encoder with valid/ready and error count.
// Ports: in_* stream in, out_* stream out, err_cnt/err_clr saturating counter.
module onehot_encoder_pipe
  import encoder_pkg::*;
#(
  parameter  int N     = 5,
  parameter  int MODE  = 0,
  parameter  int CNT_W = 16,
  localparam int IDX_W = clog2_f(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_hit,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam int PW = IDX_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Payload layout: {hit, err, idx}.
  function automatic logic [PW-1:0] encode(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    int               pop;
    logic             hit;
    logic             err;
    idx = '0;
    pop = 0;
    // Walking down leaves the lowest set bit in idx.
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
        pop++;
      end
    end
    hit = |v;
    err = !hit || (MODE == ENC_MODE_STRICT && pop > 1);
    if (err) idx = '0;
    return {hit, err, idx};
  endfunction

  logic [PW-1:0]    enc;
  logic [PW-1:0]    out_data;
  logic             accept;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign enc    = encode(in_vec);
  assign accept = in_valid && in_ready;

  stream_skid_reg #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (enc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign out_idx = out_data[IDX_W-1:0];
  assign out_err = out_data[IDX_W];
  assign out_hit = out_data[IDX_W+1];

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && enc[IDX_W] && err_cnt_q != CNT_MAX) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Directed bench for onehot_encoder_pipe across three configurations.
// a_*: N=5 strict, b_*: N=8 priority, c_*: N=5 strict with 2-bit counter.
module tb_onehot_encoder_pipe;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [4:0] a_in_vec;
  logic [2:0] a_out_idx;
  logic       a_out_hit, a_out_err, a_err_clr;
  logic [15:0] a_err_cnt;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_vec;
  logic [2:0] b_out_idx;
  logic       b_out_hit, b_out_err, b_err_clr;
  logic [15:0] b_err_cnt;

  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [4:0] c_in_vec;
  logic [2:0] c_out_idx;
  logic       c_out_hit, c_out_err, c_err_clr;
  logic [1:0] c_err_cnt;

  onehot_encoder_pipe #(.N(5), .MODE(ENC_MODE_STRICT), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_idx(a_out_idx), .out_hit(a_out_hit), .out_err(a_out_err),
    .err_cnt(a_err_cnt), .err_clr(a_err_clr)
  );

  onehot_encoder_pipe #(.N(8), .MODE(ENC_MODE_PRIO), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_idx(b_out_idx), .out_hit(b_out_hit), .out_err(b_out_err),
    .err_cnt(b_err_cnt), .err_clr(b_err_clr)
  );

  onehot_encoder_pipe #(.N(5), .MODE(ENC_MODE_STRICT), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_vec(c_in_vec),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_idx(c_out_idx), .out_hit(c_out_hit), .out_err(c_out_err),
    .err_cnt(c_err_cnt), .err_clr(c_err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_idx !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", a_out_idx); end
    checks++; if ({a_out_hit, a_out_err} !== 2'b00) begin errors++; $display("FAIL rst_hit_err: got %b expected 00", {a_out_hit, a_out_err}); end
    checks++; if (a_err_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", a_err_cnt); end
    rst_n = 1'b1;
    step();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_post: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_in_vec = 5'(1 << i);
      step();
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b expected 1", i, a_out_valid); end
      checks++; if (a_out_idx !== 3'(i)) begin errors++; $display("FAIL b2b_idx%0d: got %0d expected %0d", i, a_out_idx, i); end
      checks++; if ({a_out_hit, a_out_err} !== 2'b10) begin errors++; $display("FAIL b2b_hit_err%0d: got %b expected 10", i, {a_out_hit, a_out_err}); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, a_in_ready); end
    end
    a_in_valid = 1'b0;
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", a_out_valid); end
    checks++; if (a_err_cnt !== 16'd0) begin errors++; $display("FAIL b2b_cnt: got %0d expected 0", a_err_cnt); end
  endtask

  task automatic test_strict_invalid();
    a_in_valid = 1'b1;
    a_in_vec   = 5'b00000;
    step();
    checks++; if ({a_out_hit, a_out_err, a_out_idx} !== 5'b01_000) begin errors++; $display("FAIL zero_vec: got %b expected 01000", {a_out_hit, a_out_err, a_out_idx}); end
    a_in_vec = 5'b00110;
    step();
    checks++; if ({a_out_hit, a_out_err, a_out_idx} !== 5'b11_000) begin errors++; $display("FAIL multi_hot: got %b expected 11000", {a_out_hit, a_out_err, a_out_idx}); end
    a_in_valid = 1'b0;
    step();
    checks++; if (a_err_cnt !== 16'd2) begin errors++; $display("FAIL strict_cnt: got %0d expected 2", a_err_cnt); end
  endtask

  task automatic test_priority();
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_vec    = 8'b1011_0100;
    step();
    checks++; if ({b_out_valid, b_out_hit, b_out_err, b_out_idx} !== 6'b110_010) begin errors++; $display("FAIL prio_lowest: got %b expected 110010", {b_out_valid, b_out_hit, b_out_err, b_out_idx}); end
    b_in_vec = 8'b1000_0000;
    step();
    checks++; if ({b_out_hit, b_out_err, b_out_idx} !== 5'b10_111) begin errors++; $display("FAIL prio_top: got %b expected 10111", {b_out_hit, b_out_err, b_out_idx}); end
    b_in_vec = 8'b0000_0000;
    step();
    checks++; if ({b_out_hit, b_out_err, b_out_idx} !== 5'b01_000) begin errors++; $display("FAIL prio_zero: got %b expected 01000", {b_out_hit, b_out_err, b_out_idx}); end
    b_in_valid = 1'b0;
    step();
    checks++; if (b_err_cnt !== 16'd1) begin errors++; $display("FAIL prio_cnt: got %0d expected 1", b_err_cnt); end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_vec    = 5'b00100;
    step();
    checks++; if ({a_out_valid, a_out_idx} !== 4'b1_010) begin errors++; $display("FAIL bp_a_out: got %b expected 1010", {a_out_valid, a_out_idx}); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a: got %b expected 1", a_in_ready); end
    a_in_vec = 5'b10000;
    step();
    a_in_valid = 1'b0;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_b: got %b expected 0", a_in_ready); end
    checks++; if ({a_out_valid, a_out_idx} !== 4'b1_010) begin errors++; $display("FAIL bp_hold1: got %b expected 1010", {a_out_valid, a_out_idx}); end
    step();
    checks++; if ({a_out_valid, a_out_idx} !== 4'b1_010) begin errors++; $display("FAIL bp_hold2: got %b expected 1010", {a_out_valid, a_out_idx}); end
    a_out_ready = 1'b1;
    step();
    checks++; if ({a_out_valid, a_out_idx} !== 4'b1_100) begin errors++; $display("FAIL bp_b_out: got %b expected 1100", {a_out_valid, a_out_idx}); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", a_in_ready); end
    step();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", a_out_valid); end
    checks++; if (a_err_cnt !== 16'd2) begin errors++; $display("FAIL bp_cnt: got %0d expected 2", a_err_cnt); end
  endtask

  task automatic test_saturation();
    c_out_ready = 1'b1;
    c_in_valid  = 1'b1;
    c_in_vec    = 5'b00000;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (c_err_cnt !== 2'((k > 3) ? 3 : k)) begin errors++; $display("FAIL sat_cnt%0d: got %0d expected %0d", k, c_err_cnt, (k > 3) ? 3 : k); end
    end
    c_in_vec  = 5'b11000;
    c_err_clr = 1'b1;
    step();
    checks++; if (c_err_cnt !== 2'd0) begin errors++; $display("FAIL clr_prio: got %0d expected 0", c_err_cnt); end
    checks++; if ({c_out_hit, c_out_err} !== 2'b11) begin errors++; $display("FAIL clr_vec: got %b expected 11", {c_out_hit, c_out_err}); end
    c_err_clr  = 1'b0;
    c_in_valid = 1'b0;
    step();
    checks++; if (c_err_cnt !== 2'd0) begin errors++; $display("FAIL clr_hold: got %0d expected 0", c_err_cnt); end
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_vec    = 5'b00010;
    step();
    a_in_vec = 5'b01000;
    step();
    a_in_valid = 1'b0;
    checks++; if ({a_out_valid, a_in_ready} !== 2'b10) begin errors++; $display("FAIL ar_full: got %b expected 10", {a_out_valid, a_in_ready}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({a_out_valid, a_in_ready} !== 2'b01) begin errors++; $display("FAIL ar_async: got %b expected 01", {a_out_valid, a_in_ready}); end
    checks++; if (a_err_cnt !== 16'd0) begin errors++; $display("FAIL ar_cnt: got %0d expected 0", a_err_cnt); end
    step();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if ({a_out_valid, a_in_ready} !== 2'b01) begin errors++; $display("FAIL ar_stale%0d: got %b expected 01", k, {a_out_valid, a_in_ready}); end
    end
  endtask

  initial begin
    a_in_valid = 1'b0; a_in_vec = '0; a_out_ready = 1'b0; a_err_clr = 1'b0;
    b_in_valid = 1'b0; b_in_vec = '0; b_out_ready = 1'b0; b_err_clr = 1'b0;
    c_in_valid = 1'b0; c_in_vec = '0; c_out_ready = 1'b0; c_err_clr = 1'b0;
    test_reset();
    test_back_to_back();
    test_strict_invalid();
    test_priority();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
